// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are shifted out LSB-first through a
// two-half-adder full-add stage with a registered carry, under start/busy/done.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             p_lo;
    logic             g_lo;
    logic             s_bit;
    logic             g_hi;
    logic             carry_next;

    // Full add of the current LSBs: propagate/generate from the operand bits,
    // then fold in the stored carry with the second half adder.
    half_adder u_ha_lo (
        .a (sa[0]),
        .b (sb[0]),
        .s (p_lo),
        .c (g_lo)
    );

    half_adder u_ha_hi (
        .a (p_lo),
        .b (carry),
        .s (s_bit),
        .c (g_hi)
    );

    assign carry_next = g_lo | g_hi;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of sa/sb/carry/res; blocking assignments would let the
    // shift and the carry update race each other within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a_in;
                        sb    <= b_in;
                        res   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    carry <= carry_next;
                    res   <= {s_bit, res[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    // Result registers move only on the final bit so the
                    // outputs never expose a partially shifted sum.
                    if (cnt == LAST_BIT) begin
                        sum_out  <= {s_bit, res[WIDTH-1:1]};
                        cout_out <= carry_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a_in;
                        sb    <= b_in;
                        res   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for timing, carry,
// back-to-back and abort scenarios, and a 4-bit instance for a full sweep.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .a_in     (a8),
        .b_in     (b8),
        .busy     (busy8),
        .done     (done8),
        .sum_out  (sum8),
        .cout_out (cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .a_in     (a4),
        .b_in     (b4),
        .busy     (busy4),
        .done     (done4),
        .sum_out  (sum4),
        .cout_out (cout4)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one 8-bit add from IDLE and wait (bounded) for its done pulse.
    task automatic run_add8(input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] s, output logic c,
                            output bit timed_out);
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        tick();
        start8    = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8) begin
                timed_out = 1'b0;
                break;
            end
        end
        s = sum8;
        c = cout8;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        tick();
        tick();
        total++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            bad++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum8, cout8);
        end
        total++;
        if ({busy4, done4, sum4, cout4} !== 7'd0) begin
            bad++;
            $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy4, done4, sum4, cout4);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        a8     = 8'h03;
        b8     = 8'h05;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL basic_accept: got busy=%b done=%b, want busy=1 done=0", busy8, done8);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (i < 8) begin
                if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h00) begin
                    bad++;
                    $display("FAIL basic_run cycle %0d: got busy=%b done=%b sum=%h, want 1 0 00",
                             i, busy8, done8, sum8);
                end
            end else begin
                if (busy8 !== 1'b0 || done8 !== 1'b1 || sum8 !== 8'h08 || cout8 !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_done: got busy=%b done=%b sum=%h cout=%b, want 0 1 08 0",
                             busy8, done8, sum8, cout8);
                end
            end
        end
        tick();
        total++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h08) begin
            bad++;
            $display("FAIL basic_after: got done=%b busy=%b sum=%h, want 0 0 08 held",
                     done8, busy8, sum8);
        end
    endtask

    task automatic test_carry();
        logic [7:0] s;
        logic       c;
        bit         to;
        run_add8(8'hFF, 8'h01, s, c, to);
        total++;
        if (to || s !== 8'h00 || c !== 1'b1) begin
            bad++;
            $display("FAIL carry_ff_01: timeout=%0d sum=%h cout=%b, want sum=00 cout=1", to, s, c);
        end
        tick();
        run_add8(8'hFF, 8'hFF, s, c, to);
        total++;
        if (to || s !== 8'hFE || c !== 1'b1) begin
            bad++;
            $display("FAIL carry_ff_ff: timeout=%0d sum=%h cout=%b, want sum=FE cout=1", to, s, c);
        end
        tick();
    endtask

    // Start held high: the DONE cycle reloads, so successive done pulses are
    // WIDTH+1 edges apart and the second add uses operands present at reload.
    task automatic test_back_to_back();
        int n;
        a8     = 8'h10;
        b8     = 8'h20;
        start8 = 1'b1;
        tick();
        a8 = 8'h77;
        b8 = 8'h11;
        n  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done8) begin
                n = i;
                break;
            end
        end
        total++;
        if (n !== 8 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: done after %0d edges sum=%h cout=%b, want 8 edges sum=30 cout=0",
                     n, sum8, cout8);
        end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done8) begin
                n = i;
                break;
            end
        end
        start8 = 1'b0;
        total++;
        if (n !== 9 || sum8 !== 8'h88 || cout8 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: done after %0d edges sum=%h cout=%b, want 9 edges sum=88 cout=0",
                     n, sum8, cout8);
        end
        tick();
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy8, done8);
        end
    endtask

    task automatic test_abort();
        int         seen;
        logic [7:0] s;
        logic       c;
        bit         to;
        a8     = 8'hAA;
        b8     = 8'h55;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            bad++;
            $display("FAIL abort_async: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy8, done8, sum8, cout8);
        end
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_done: saw %0d done pulses, want 0", seen);
        end
        run_add8(8'h01, 8'h01, s, c, to);
        total++;
        if (to || s !== 8'h02 || c !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart: timeout=%0d sum=%h cout=%b, want sum=02 cout=0", to, s, c);
        end
        tick();
    endtask

    task automatic test_sweep4();
        logic [4:0] expq[$];
        logic [4:0] exp_v;
        bit         got;
        for (int i = 0; i < 256; i++) begin
            a4     = 4'(i >> 4);
            b4     = 4'(i);
            start4 = 1'b1;
            expq.push_back({1'b0, a4} + {1'b0, b4});
            tick();
            start4 = 1'b0;
            got    = 1'b0;
            for (int j = 0; j < 12; j++) begin
                tick();
                if (done4) begin
                    got = 1'b1;
                    break;
                end
            end
            exp_v = expq.pop_front();
            total++;
            if (!got || {cout4, sum4} !== exp_v) begin
                bad++;
                $display("FAIL sweep4 a=%h b=%h: done=%0d got %h, want %h",
                         i >> 4, i & 15, got, {cout4, sum4}, exp_v);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_abort();
        test_sweep4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
